// File: rtl/eth_rmii_tx_if.sv
// Byte-stream input and RMII transmit side of the eth_rmii_tx framer.
interface eth_rmii_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [1:0] txd;
    logic       txen;
    logic       busy;
    logic       underrun;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, txd, txen, busy, underrun
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, txd, txen, busy, underrun
    );
endinterface

// File: rtl/eth_rmii_tx.sv
// RMII transmit framer: preamble/SFD, LSb-first byte serialisation two bits
// per clock, zero padding to a minimum length, CRC-32 FCS and inter-frame gap.
module eth_rmii_tx #(
    parameter int unsigned MIN_FRAME  = 60,
    parameter int unsigned IFG_CYCLES = 48
) (
    input  logic         clk,
    input  logic         rst,
    eth_rmii_tx_if.slave bus
);
    localparam logic [31:0]   CRC_POLY = 32'h04C1_1DB7;
    localparam int unsigned   IW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);
    localparam logic [10:0]   MIN_CNT  = 11'(MIN_FRAME);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG} state_t;

    state_t        state;
    logic [4:0]    dib;       // dibit index within preamble, byte or FCS
    logic [IW-1:0] ifg_cnt;
    logic [10:0]   byte_cnt;  // payload plus pad bytes started so far
    logic [5:0]    sr;        // remaining dibits of the byte in flight
    logic          last_q;
    logic [31:0]   crc;

    // Shift one dibit into the CRC register, txd[0] first, MSB feedback
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 2; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == '1) ? v : v + 11'd1;
    endfunction

    assign bus.busy = (state != IDLE);

    // Frame sequencer; CRC advances on the dibit being loaded into txd so the
    // register is complete when the first FCS dibit must be loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.txd      <= '0;
            bus.txen     <= 1'b0;
            bus.s_ready  <= 1'b0;
            bus.underrun <= 1'b0;
            dib          <= '0;
            ifg_cnt      <= '0;
            byte_cnt     <= '0;
            sr           <= '0;
            last_q       <= 1'b0;
            crc          <= '1;
        end else begin
            bus.s_ready  <= 1'b0;
            bus.underrun <= 1'b0;
            if (bus.s_ready) begin
                // s_ready only rises in byte slots (SFD dibit or 4th dibit of a
                // non-last byte), so this one branch serves both states.
                if (bus.s_valid) begin
                    state    <= PAYLOAD;
                    dib      <= '0;
                    bus.txd  <= bus.s_data[1:0];
                    crc      <= crc_dibit(crc, bus.s_data[1:0]);
                    sr       <= bus.s_data[7:2];
                    last_q   <= bus.s_last;
                    byte_cnt <= sat_inc(byte_cnt);
                end else begin
                    state        <= IFG;
                    ifg_cnt      <= '0;
                    bus.txen     <= 1'b0;
                    bus.txd      <= '0;
                    bus.underrun <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.s_valid) begin
                            state    <= PREAMBLE;
                            dib      <= '0;
                            bus.txen <= 1'b1;
                            bus.txd  <= 2'b01;
                            crc      <= '1;
                            byte_cnt <= '0;
                        end
                    end
                    PREAMBLE: begin
                        dib <= dib + 5'd1;
                        if (dib == 5'd30) begin
                            bus.txd     <= 2'b11;
                            bus.s_ready <= 1'b1;
                        end
                    end
                    PAYLOAD, PAD: begin
                        dib <= dib + 5'd1;
                        if (dib[1:0] != 2'd3) begin
                            bus.txd <= sr[1:0];
                            crc     <= crc_dibit(crc, sr[1:0]);
                            sr      <= {2'b00, sr[5:2]};
                            if (state == PAYLOAD && dib[1:0] == 2'd2 && !last_q)
                                bus.s_ready <= 1'b1;
                        end else if (byte_cnt < MIN_CNT) begin
                            state    <= PAD;
                            dib      <= '0;
                            bus.txd  <= 2'b00;
                            crc      <= crc_dibit(crc, 2'b00);
                            sr       <= '0;
                            byte_cnt <= sat_inc(byte_cnt);
                        end else begin
                            state   <= FCS;
                            dib     <= '0;
                            bus.txd <= {~crc[30], ~crc[31]};
                            crc     <= {crc[29:0], 2'b00};
                        end
                    end
                    FCS: begin
                        dib <= dib + 5'd1;
                        if (dib == 5'd15) begin
                            state    <= IFG;
                            ifg_cnt  <= '0;
                            bus.txen <= 1'b0;
                            bus.txd  <= '0;
                        end else begin
                            bus.txd <= {~crc[30], ~crc[31]};
                            crc     <= {crc[29:0], 2'b00};
                        end
                    end
                    IFG: begin
                        if (ifg_cnt == IFG_LAST) state <= IDLE;
                        else                     ifg_cnt <= ifg_cnt + IW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_rmii_tx.sv
// Directed bench for eth_rmii_tx: captures the wire stream of each frame and
// checks timing, preamble, payload/pad bits, FCS and CRC residue.
module tb_eth_rmii_tx;
    logic clk = 1'b0;
    logic rst;
    eth_rmii_tx_if bus ();

    eth_rmii_tx #(.MIN_FRAME(60), .IFG_CYCLES(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int abs_cyc = 0;
    logic [7:0] payload[$];
    logic wire_bits[$];
    int txen_cycles, acc, rdy_pulses, bad_period, under_pulses, txen_glitch;
    int t_on, t_off, t_idle, t_under, t_rst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame from payload[] and record everything seen on the wire
    task automatic run_frame(input int drop_after, input int rst_after, input bit hold_next);
        int idx;
        int last_rdy;
        bit rdy_pre;
        bit acc_now;
        wire_bits.delete();
        txen_cycles = 0; acc = 0; rdy_pulses = 0; bad_period = 0;
        under_pulses = 0; txen_glitch = 0;
        t_on = -1; t_off = -1; t_idle = -1; t_under = -1; t_rst = -1;
        idx = 0; last_rdy = -1;
        bus.s_valid = 1'b1; bus.s_data = 8'hC3; bus.s_last = 1'b1;
        rdy_pre = bus.s_ready;
        for (int c = 0; c < 3000 && t_idle < 0; c++) begin
            @(posedge clk);
            acc_now = rdy_pre && bus.s_valid;
            #1;
            abs_cyc++;
            if (bus.txen) begin
                if (t_off >= 0) txen_glitch++;
                if (t_on < 0) t_on = abs_cyc;
                txen_cycles++;
                wire_bits.push_back(bus.txd[0]);
                wire_bits.push_back(bus.txd[1]);
            end else if (t_on >= 0 && t_off < 0) begin
                t_off = abs_cyc;
            end
            if (bus.underrun) begin under_pulses++; t_under = abs_cyc; end
            if (bus.s_ready) begin
                rdy_pulses++;
                if (last_rdy >= 0 && abs_cyc - last_rdy != 4) bad_period++;
                last_rdy = abs_cyc;
            end
            if (t_off >= 0 && !bus.busy) t_idle = abs_cyc;
            if (acc_now) begin acc++; idx++; end
            if (rst) begin
                rst = 1'b0;
                bus.s_valid = 1'b0;
            end else begin
                if (rst_after >= 0 && acc == rst_after && t_rst < 0) begin
                    rst = 1'b1;
                    t_rst = abs_cyc;
                end
                if (drop_after >= 0 && acc >= drop_after) bus.s_valid = 1'b0;
                else if (idx < payload.size() || hold_next) bus.s_valid = 1'b1;
                else bus.s_valid = 1'b0;
                // Real data only in byte slots; junk elsewhere must be ignored
                if (bus.s_ready && idx < payload.size()) begin
                    bus.s_data = payload[idx];
                    bus.s_last = (idx == payload.size() - 1);
                end else begin
                    bus.s_data = 8'hC3;
                    bus.s_last = 1'b1;
                end
            end
            rdy_pre = bus.s_ready;
        end
        chk("frame_done", (t_idle >= 0) ? 64'd1 : 64'd0, 64'd1);
    endtask

    function automatic logic wbit(input int i);
        return (i < wire_bits.size()) ? wire_bits[i] : 1'bx;
    endfunction

    function automatic int nbytes();
        return (payload.size() < 60) ? 60 : payload.size();
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        return (k < payload.size()) ? payload[k] : 8'h00;
    endfunction

    function automatic int data_errs();
        int e = 0;
        for (int k = 0; k < nbytes(); k++) begin
            logic [7:0] b;
            b = exp_byte(k);
            for (int j = 0; j < 8; j++) if (wbit(64 + 8 * k + j) !== b[j]) e++;
        end
        return e;
    endfunction

    // Reflected byte-wise CRC-32; FCS goes out bit 0 first
    function automatic logic [31:0] fcs_model();
        logic [31:0] c = '1;
        for (int k = 0; k < nbytes(); k++) begin
            c = c ^ {24'h0, exp_byte(k)};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] fcs_seen();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = wbit(64 + 8 * nbytes() + i);
        return w;
    endfunction

    function automatic logic [31:0] residue();
        logic [31:0] r = '1;
        for (int i = 64; i < wire_bits.size(); i++) begin
            logic fb;
            fb = r[31] ^ wire_bits[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    function automatic logic [63:0] pre_seen();
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = wbit(i);
        return w;
    endfunction

    task automatic frame_checks(input string tag);
        chk({tag, "_preamble"}, pre_seen(), 64'hD555_5555_5555_5555);
        chk({tag, "_data_bits"}, 64'(data_errs()), 64'd0);
        chk({tag, "_fcs"}, 64'(fcs_seen()), 64'(fcs_model()));
        chk({tag, "_residue"}, 64'(residue()), 64'hC704_DD7B);
        chk({tag, "_gap_txen"}, 64'(txen_glitch), 64'd0);
    endtask

    initial begin
        int start;
        int off_prev;
        int ones;
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txen", 64'(bus.txen), 64'd0);
        chk("rst_txd", 64'(bus.txd), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_underrun", 64'(bus.underrun), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Short frame: one byte padded to 60
        payload = {8'hAB};
        start = abs_cyc;
        run_frame(-1, -1, 1'b0);
        chk("a_start_latency", 64'(t_on - start), 64'd1);
        chk("a_txen_cycles", 64'(txen_cycles), 64'd288);
        chk("a_accepts", 64'(acc), 64'd1);
        chk("a_ifg", 64'(t_idle - t_off), 64'd48);
        frame_checks("a");

        // 64-byte frame, no padding
        payload.delete();
        for (int i = 0; i < 64; i++) payload.push_back(8'(i));
        run_frame(-1, -1, 1'b0);
        chk("b_txen_cycles", 64'(txen_cycles), 64'd304);
        chk("b_ready_pulses", 64'(rdy_pulses), 64'd64);
        chk("b_ready_period", 64'(bad_period), 64'd0);
        chk("b_accepts", 64'(acc), 64'd64);
        frame_checks("b");

        // Underrun after 10 bytes
        payload.delete();
        for (int i = 0; i < 20; i++) payload.push_back(8'(8'h10 + i));
        run_frame(10, -1, 1'b0);
        chk("u_accepts", 64'(acc), 64'd10);
        chk("u_pulses", 64'(under_pulses), 64'd1);
        chk("u_pulse_at_drop", 64'(t_under - t_off), 64'd0);
        chk("u_txen_cycles", 64'(txen_cycles), 64'd72);
        chk("u_ifg", 64'(t_idle - t_off), 64'd48);

        // Back-to-back frames with s_valid held through the gap
        payload = {8'hDE, 8'hAD, 8'hBE};
        run_frame(-1, -1, 1'b1);
        frame_checks("c");
        off_prev = t_off;
        payload = {8'h5A, 8'hA5};
        run_frame(-1, -1, 1'b0);
        chk("b2b_gap", 64'(t_on - off_prev), 64'd49);
        frame_checks("d");

        // Reset pulse during byte 20
        payload.delete();
        for (int i = 0; i < 40; i++) payload.push_back(8'(i * 7));
        run_frame(-1, 20, 1'b0);
        chk("r_txen_drop", 64'(t_off - t_rst), 64'd1);
        chk("r_busy_drop", 64'(t_idle - t_off), 64'd0);
        chk("r_accepts", 64'(acc), 64'd20);
        ones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            abs_cyc++;
            if (bus.txen || bus.busy) ones++;
        end
        chk("r_quiet_after", 64'(ones), 64'd0);

        // Exactly MIN_FRAME bytes: no padding, clean CRC after reset
        payload.delete();
        for (int i = 0; i < 60; i++) payload.push_back(8'(8'hF0 ^ i));
        run_frame(-1, -1, 1'b0);
        chk("f_txen_cycles", 64'(txen_cycles), 64'd288);
        chk("f_accepts", 64'(acc), 64'd60);
        frame_checks("f");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_rmii_tx.md
ETH_RMII_TX -- requirements
Module: eth_rmii_tx

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, meaning the minimum count of payload plus pad bytes before the FCS.
REQ-002 SHALL have parameter IFG_CYCLES, default 48, meaning the inter-frame gap length in clk cycles (12 bytes at 2 bits/clk).
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz RMII reference clock; one dibit is transmitted per cycle.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_data, input, 8 bits: payload byte (destination MAC through end of payload).
REQ-006 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 SHALL have port s_last, input, 1 bit: qualifies s_data as the final payload byte.
REQ-008 SHALL have port s_ready, output, 1 bit: a byte is accepted when s_valid && s_ready.
REQ-009 SHALL have port txd, output, 2 bits: RMII transmit dibit; txd[0] is the earlier bit on the wire.
REQ-010 SHALL have port txen, output, 1 bit: RMII transmit enable.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, PAYLOAD, PAD, FCS and IFG; txd, txen, s_ready and underrun SHALL be registered.
REQ-014 IDLE: txen=0, txd=00, s_ready=0; s_valid=1 in cycle N SHALL move to PREAMBLE, with txen=1 from cycle N+1.
REQ-015 PREAMBLE: SHALL drive 32 dibits, 31 of txd=01 followed by 1 of txd=11 (7x 0x55, then 0xD5), in cycles N+1..N+32.
REQ-016 s_ready SHALL be high in the last PREAMBLE cycle and in the 4th dibit cycle of each non-last payload byte, and low otherwise.
REQ-017 An accepted byte SHALL go out LSb first as 4 dibits (bits [1:0], [3:2], [5:4], [7:6]), its first dibit in the cycle after acceptance, with no gaps between bytes.
REQ-018 s_valid=0 while s_ready=1 in PAYLOAD SHALL abort the frame: txen=0 next cycle, underrun pulses for 1 cycle, and the state goes to IFG with no FCS sent.
REQ-019 Accepted with s_last=1: if the byte count including this byte is < MIN_FRAME, go to PAD; otherwise go to FCS after its 4th dibit.
REQ-020 PAD: SHALL transmit 0x00 bytes until the byte count equals MIN_FRAME.
REQ-021 The byte counter SHALL be 11 bits, saturating at 2047, with no maximum-length enforcement.
REQ-022 CRC-32 state: polynomial 0x04C11DB7, initialised to 0xFFFFFFFF at frame start.
REQ-023 CRC-32 update: each transmitted payload/pad dibit is shifted in txd[0] first, with feedback from bit 31.
REQ-024 FCS: SHALL be 16 dibits of the bitwise-inverted CRC register, transmitted bit 31 first: dibit k has txd[0]=~crc[31-2k] and txd[1]=~crc[30-2k].
REQ-025 IFG: txen=0, txd=00 and s_ready=0 for exactly IFG_CYCLES cycles, then IDLE; s_valid is ignored during IFG.
REQ-026 Frames SHALL be back-to-back: if s_valid=1 in the first IDLE cycle, the next preamble begins 1 cycle later.
REQ-027 s_data and s_last SHALL be ignored in cycles where no byte is accepted.

Reset
REQ-028 rst=1 SHALL force IDLE, txen=0, txd=00, s_ready=0, busy=0, underrun=0, CRC=0xFFFFFFFF and byte count 0.
REQ-029 rst asserted mid-frame SHALL drop txen at the next edge, with no FCS and no IFG; the held s_valid byte is not consumed.

Verification
REQ-030 Short frame: one byte 0xAB with s_last -> txen high for exactly 288 cycles (32+240+16); 59 zero pad bytes; then 48 cycles txen=0.
REQ-031 Preamble and FCS check: any frame -> dibits 31x 01 then 11; an independent CRC-32 model run over payload, pad and FCS dibits SHALL end at residue 0xC704DD7B.
REQ-032 No-pad frame: 64 bytes 0x00..0x3F -> txen high 304 cycles, no pad, s_ready pulse period 4 cycles, 64 acceptances total.
REQ-033 Underrun: s_valid dropped after 10 accepted bytes -> underrun=1 for 1 cycle, txen=0 next cycle, no FCS, then 48 IFG cycles and busy=0.
REQ-034 Back-to-back: second frame's s_valid held throughout IFG -> its first preamble dibit appears exactly 49 cycles after txen falls.
REQ-035 Reset mid-payload: rst pulsed during byte 20 -> txen=0 next cycle, busy=0; the next frame starts cleanly with a correct FCS.
